// File: rtl/rot_seq_ctrl_if.sv
// Handshake/operand bundle between the rotate sequencer, its requester and the
// downstream 1-bit rotate-right register (RR).
interface rot_seq_ctrl_if #(
  parameter int AMT_W = 2
);
  logic             start;
  logic [3:0]       din;
  logic [AMT_W-1:0] amt;
  logic [3:0]       q;
  logic [3:0]       s;
  logic [3:0]       r;
  logic             busy;
  logic             done;
  logic [3:0]       dout;

  // Requester and RR side: drives the request and RR's registered result.
  modport master (
    output start, din, amt, r,
    input  q, s, busy, done, dout
  );

  // Sequencer side.
  modport slave (
    input  start, din, amt, r,
    output q, s, busy, done, dout
  );
endinterface

// File: rtl/rot_seq_ctrl.sv
// Multi-step rotate sequencer: steps the external rotate-right-by-one register
// amt times, feeding each registered result back as the next operand.
module rot_seq_ctrl #(
  parameter logic [3:0] OPC_ROR = 4'b0100,
  parameter logic [3:0] OPC_NOP = 4'b0000,
  parameter int         AMT_W   = 2
) (
  input  logic         clk,
  input  logic         Reset,
  rot_seq_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [3:0]       cur;
  logic [AMT_W-1:0] cnt;
  logic [3:0]       q;
  logic [3:0]       s;
  logic [3:0]       dout;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      q     <= '0;
      s     <= OPC_NOP;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          s <= OPC_NOP;
          if (bus.start) begin
            cur <= bus.din;
            cnt <= bus.amt;
            if (bus.amt == '0) begin
              state <= DONE;
              dout  <= bus.din;
            end else begin
              state <= ISSUE;
              q     <= bus.din;
              s     <= OPC_ROR;
            end
          end
        end
        ISSUE: begin
          // RR captures q/s on this edge; the opcode is withdrawn so it never
          // stays asserted for two consecutive cycles.
          state <= WAIT;
          s     <= OPC_NOP;
        end
        WAIT: begin
          cur <= bus.r;
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            dout  <= bus.r;
          end else begin
            state <= ISSUE;
            q     <= bus.r;
            s     <= OPC_ROR;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.q    = q;
  assign bus.s    = s;
  assign bus.dout = dout;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  // Sanity properties on the sequencing and on the attached RR.
  a_no_back_to_back_ror: assert property (
    @(posedge clk) disable iff (!Reset)
      (s == OPC_ROR) |=> (s != OPC_ROR));

  a_wait_cnt_nonzero: assert property (
    @(posedge clk) disable iff (!Reset)
      (state == WAIT) |-> (cnt != '0));

  a_rr_result: assert property (
    @(posedge clk) disable iff (!Reset)
      (state == WAIT) |-> (bus.r == {cur[0], cur[3:1]}));

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Bench for rot_seq_ctrl: models RR, directed literal scenarios, then random
// stimulus checked every cycle against a latency/arithmetic reference model.
module tb_rot_seq_ctrl;

  localparam logic [3:0] ROR = 4'b0100;
  localparam logic [3:0] NOP = 4'b0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rot_seq_ctrl_if #(.AMT_W(2)) bus ();

  rot_seq_ctrl #(
    .OPC_ROR(ROR),
    .OPC_NOP(NOP),
    .AMT_W  (2)
  ) dut (
    .clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream rotate-right register.
  always_ff @(posedge clk) begin
    bus.r <= (bus.s == ROR) ? {bus.q[0], bus.q[3:1]} : 4'b0000;
  end

  function automatic logic [3:0] rotr(input logic [3:0] d, input int k);
    logic [7:0] t;
    t = {d, d} >> (k % 4);
    return t[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: n counts edges since the accepting edge (1 = accepting edge).
  int         n;
  int         m_amt;
  logic [3:0] m_din;
  logic [3:0] m_dout;
  bit         mvalid;

  initial begin
    n = 0; m_amt = 0; m_din = '0; m_dout = '0; mvalid = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      m_dout = '0;
      mvalid = 1;
    end else if (n == 0) begin
      if (bus.start) begin
        n = 1;
        m_din = bus.din;
        m_amt = int'(bus.amt);
        if (m_amt == 0) m_dout = bus.din;
      end
    end else begin
      n++;
      if (n > 2 * m_amt + 1) n = 0;
      else if (n == 2 * m_amt + 1) m_dout = rotr(m_din, m_amt);
    end
  end

  always @(posedge clk) begin
    int  last;
    bit  e_ror;
    #1;
    if (mvalid) begin
      last  = 2 * m_amt + 1;
      e_ror = (n != 0) && (n % 2 == 1) && (n < last);
      chk("busy", 32'(bus.busy), 32'(n != 0));
      chk("done", 32'(bus.done), 32'((n != 0) && (n == last)));
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("s",    32'(bus.s),    32'(e_ror ? ROR : NOP));
      if (e_ror) chk("q", 32'(bus.q), 32'(rotr(m_din, (n - 1) / 2)));
    end
  end

  // One request; glitch > 0 re-pulses start (din=1111) at that edge count.
  task automatic run_op(input string nm, input logic [3:0] d, input logic [1:0] a,
                        input logic [3:0] exp_dout, input int exp_edges, input int glitch);
    int e;
    @(negedge clk);
    bus.start = 1'b1; bus.din = d; bus.amt = a;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && e < 20) begin
      chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
      if (e == glitch) begin
        bus.start = 1'b1; bus.din = 4'b1111; bus.amt = 2'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({nm, "_edges"}, 32'(e), 32'(exp_edges));
    chk({nm, "_dout"}, 32'(bus.dout), 32'(exp_dout));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.din = 4'hf; bus.amt = 2'd3;

    // T1: reset wins over start
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_done", 32'(bus.done), 32'd0);
    chk("t1_dout", 32'(bus.dout), 32'd0);
    chk("t1_s",    32'(bus.s),    32'd0);
    chk("t1_q",    32'(bus.q),    32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("t2", 4'b0001, 2'd1, 4'b1000, 3, 0);
    run_op("t3", 4'b1011, 2'd3, 4'b0111, 7, 0);
    run_op("t4", 4'b0110, 2'd0, 4'b0110, 1, 0);
    run_op("t5", 4'b1011, 2'd3, 4'b0111, 7, 2);

    // T6: reset while in WAIT
    @(negedge clk);
    bus.start = 1'b1; bus.din = 4'b1011; bus.amt = 2'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_dout", 32'(bus.dout), 32'd0);
    chk("t6_s",    32'(bus.s),    32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_done", 32'(bus.done), 32'd0);
    end
    run_op("t6b", 4'b1000, 2'd2, 4'b0010, 5, 0);

    // Random phase: requests, start while busy, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 199) != 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.din   = 4'($urandom);
      bus.amt   = 2'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
